// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The controller uses the master modport and the subtractor uses the slave modport.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flip-flop.
// It consumes one bit per clock, LSB first, and reports diff = a - b mod 2^WIDTH and borrow = (a < b).
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clock,
    input logic                reset_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, r_q, diff_q;
    logic [WIDTH-1:0] r_shift;
    logic [CntW-1:0]  count_q;
    logic             borrow_q, busy_q, done_q, borrow_out_q;
    logic             a0, b0, d, bn, last;

    assign a0   = a_sr_q[0];
    assign b0   = b_sr_q[0];
    assign d    = a0 ^ b0 ^ borrow_q;
    assign bn   = (~a0 & b0) | (~a0 & borrow_q) | (b0 & borrow_q);
    assign last = (count_q == CntW'(WIDTH - 1));

    // The shift and MSB insert are written this way so that WIDTH=1 also works.
    always_comb begin
        r_shift            = r_q >> 1;
        r_shift[WIDTH-1]   = d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            r_q          <= '0;
            diff_q       <= '0;
            count_q      <= '0;
            borrow_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr_q   <= bus.a;
                        b_sr_q   <= bus.b;
                        borrow_q <= 1'b0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end else begin
                        state_q  <= StIdle;
                    end
                end
                StRun: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    r_q      <= r_shift;
                    borrow_q <= bn;
                    count_q  <= count_q + 1'b1;
                    // The result is published only here, so diff stays stable during a later run.
                    if (last) begin
                        diff_q       <= r_shift;
                        borrow_out_q <= bn;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
endmodule
